minimig_sram_ctrl: RTL



---
 rtl/minimig_sram_pkg.sv | 12 +
 rtl/minimig_bank_encoder.sv | 15 +
 rtl/minimig_sram_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/minimig_sram_pkg.sv
// minimig_sram_pkg: shared FSM state type, defaults and width helper for the SRAM controller
package minimig_sram_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  localparam int RD_WAIT_DEF = 1;
  localparam int WR_WAIT_DEF = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/minimig_bank_encoder.sv
// minimig_bank_encoder: one-hot bank select to binary index, lowest bit wins, with multi-hot flag
module minimig_bank_encoder import minimig_sram_pkg::*; #(
  parameter int BANKS = 8
) (
  input  logic [BANKS-1:0]        bank,
  output logic [clog2(BANKS)-1:0] index,
  output logic                    multi
);
  localparam int BW = clog2(BANKS);
  always_comb begin
    index = '0;
    for (int i = BANKS - 1; i >= 0; i--) index = bank[i] ? BW'(i) : index;
    multi = |(bank & (bank - BANKS'(1)));
  end
endmodule

// File: rtl/minimig_sram_ctrl.sv
// minimig_sram_ctrl: clocked req/ack bridge to asynchronous SRAM with registered strobes and wait states
module minimig_sram_ctrl import minimig_sram_pkg::*; #(
  parameter int BANKS   = 8,
  parameter int ABITS   = 18,
  parameter int DW      = 16,
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF
) (
  input  logic                           clk,
  input  logic                           _reset,
  input  logic                           req,
  input  logic [BANKS-1:0]               bank,
  input  logic [ABITS-1:0]               address_in,
  input  logic [DW-1:0]                  data_in,
  input  logic                           rd,
  input  logic [DW/8-1:0]                be,
  output logic                           ack,
  output logic [DW-1:0]                  data_out,
  output logic                           bank_err,
  output logic [ABITS+clog2(BANKS)-1:0]  address,
  output logic [DW-1:0]                  data,
  output logic                           doe,
  output logic                           _ce,
  output logic                           _oe,
  output logic                           _we,
  output logic [DW/8-1:0]                _bsel,
  input  logic [DW-1:0]                  ramdata_in
);
  localparam int BW = clog2(BANKS);
  localparam int NB = DW / 8;
  state_t state;
  logic [3:0] cnt;
  logic rd_r;
  logic [NB-1:0] be_r;
  logic [BW-1:0] idx;
  logic multi;
  minimig_bank_encoder #(.BANKS(BANKS)) u_enc (.bank(bank), .index(idx), .multi(multi));
  always_ff @(posedge clk)
    if (!_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_r     <= 1'b0;
      be_r     <= '0;
      ack      <= 1'b0;
      bank_err <= 1'b0;
      data_out <= '0;
      address  <= '0;
      data     <= '0;
      doe      <= 1'b0;
      _ce      <= 1'b1;
      _oe      <= 1'b1;
      _we      <= 1'b1;
      _bsel    <= '1;
    end else
      case (state)
        IDLE: if (req) begin
          rd_r <= rd;
          be_r <= be;
          if (bank == '0) begin
            // empty bank select: acknowledge without touching the SRAM
            state <= HOLD;
            ack   <= 1'b1;
            if (rd) data_out <= '0;
          end else begin
            state    <= SETUP;
            address  <= {idx, address_in};
            data     <= data_in;
            bank_err <= multi;
            doe      <= !rd;
            _ce      <= 1'b0;
            _oe      <= !rd;
            _bsel    <= rd ? '0 : '1;
          end
        end
        SETUP: begin
          state <= ACCESS;
          cnt   <= rd_r ? 4'(RD_WAIT) : 4'(WR_WAIT);
          if (!rd_r) begin
            _we   <= be_r == '0;
            _bsel <= ~be_r;
          end
        end
        ACCESS:
          if (cnt == 4'd0) begin
            state <= HOLD;
            ack   <= 1'b1;
            _ce   <= 1'b1;
            _oe   <= 1'b1;
            _we   <= 1'b1;
            _bsel <= '1;
            if (rd_r) data_out <= ramdata_in;
          end else cnt <= cnt - 4'd1;
        HOLD: begin
          state <= IDLE;
          ack   <= 1'b0;
          doe   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule
